// File: rtl/branch_resolve_ctrl.sv
// Early ID-stage BLTZ resolution: stalls until rs is forwardable, then decides taken from the sign bit.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve_ctrl #(
    parameter int          DATA_W  = 32,
    parameter int          REG_W   = 5,
    parameter logic [5:0]  OP_BLTZ = 6'b000001,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        id_opcode,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              mem_memread,
    input  logic [REG_W-1:0]  mem_rd,
    output logic              stall,
    output logic              pc_sel_br,
    output logic              flush_ifid,
    output logic              br_resolved,
    output logic [CNT_W-1:0]  br_taken_cnt,
    output logic [CNT_W-1:0]  br_total_cnt,
    output logic [CNT_W-1:0]  stall_cyc_cnt
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic       is_br;
    logic [1:0] haz_cyc;
    logic       resolve;
    logic       taken;

    assign is_br = (id_opcode == OP_BLTZ);

    // Cycles until rs is reachable by forwarding; r0 is hardwired so never waits.
    always_comb begin
        haz_cyc = 2'd0;
        if (id_rs != '0) begin
            if (ex_memread && (ex_rd == id_rs))
                haz_cyc = 2'd2;
            else if (ex_regwrite && (ex_rd == id_rs))
                haz_cyc = 2'd1;
            else if (mem_memread && (mem_rd == id_rs))
                haz_cyc = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (is_br && (haz_cyc != 2'd0)) begin
                    state_d = S_WAIT;
                    wcnt_d  = haz_cyc - 2'd1;
                end
            end
            S_WAIT: begin
                if (wcnt_q != 2'd0)
                    wcnt_d = wcnt_q - 2'd1;
                else
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 2'd0;
            end
        endcase
    end

    // Mealy outputs, forced quiet while reset is asserted.
    always_comb begin
        stall   = 1'b0;
        resolve = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (is_br) begin
                        if (haz_cyc != 2'd0)
                            stall = 1'b1;
                        else
                            resolve = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q != 2'd0)
                        stall = 1'b1;
                    else
                        resolve = 1'b1;
                end
                default: begin
                    stall   = 1'b0;
                    resolve = 1'b0;
                end
            endcase
        end
    end

    assign taken       = resolve && id_rs_val[DATA_W-1];
    assign br_resolved = resolve;
    assign pc_sel_br   = taken;
    assign flush_ifid  = taken;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating increments: a counter pinned at all-ones stays there.
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        total_cnt_d = total_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (taken && (taken_cnt_q != '1))
            taken_cnt_d = taken_cnt_q + 1'b1;
        if (resolve && (total_cnt_q != '1))
            total_cnt_d = total_cnt_q + 1'b1;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= '0;
            total_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            total_cnt_q <= total_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign br_taken_cnt  = taken_cnt_q;
    assign br_total_cnt  = total_cnt_q;
    assign stall_cyc_cnt = stall_cnt_q;
`else
    assign br_taken_cnt  = '0;
    assign br_total_cnt  = '0;
    assign stall_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: a pending-branch model checked every cycle plus literal spot checks.
module tb_branch_resolve_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        id_opcode;
    logic [REG_W-1:0]  id_rs;
    logic [DATA_W-1:0] id_rs_val;
    logic              ex_regwrite, ex_memread, mem_memread;
    logic [REG_W-1:0]  ex_rd, mem_rd;
    logic              stall, pc_sel_br, flush_ifid, br_resolved;
    logic [CNT_W-1:0]  br_taken_cnt, br_total_cnt, stall_cyc_cnt;

    int tests = 0;
    int fails = 0;

    branch_resolve_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_BLTZ(6'b000001), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rs_val(id_rs_val),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd),
        .stall(stall), .pc_sel_br(pc_sel_br), .flush_ifid(flush_ifid), .br_resolved(br_resolved),
        .br_taken_cnt(br_taken_cnt), .br_total_cnt(br_total_cnt), .stall_cyc_cnt(stall_cyc_cnt)
    );

    always #5 clk = ~clk;

    // Model state: whether a BLTZ is pending and how many stall cycles remain before it resolves.
    bit m_pend = 0;
    int m_left = 0;
    int m_taken = 0, m_total = 0, m_stall = 0;
    bit n_pend;
    int n_left, n_taken, n_total, n_stall;

    function automatic int hazard_cycles();
        if (id_rs == 0) return 0;
        if (ex_memread && ex_rd == id_rs) return 2;
        if (ex_regwrite && ex_rd == id_rs) return 1;
        if (mem_memread && mem_rd == id_rs) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input bit inc);
        if (inc && v < CMAX) return v + 1;
        return v;
    endfunction

    // Compare process: evaluate the model at mid-cycle against the settled DUT outputs.
    always @(negedge clk) begin
        bit e_stall, e_res, e_taken, pend;
        int left;
        e_stall = 0; e_res = 0; e_taken = 0;
        pend = m_pend; left = m_left;
        if (!reset) begin
            if (!pend && id_opcode == 6'b000001) begin
                pend = 1;
                left = hazard_cycles();
            end
            if (pend) begin
                if (left > 0) begin
                    e_stall = 1;
                    left--;
                end else begin
                    e_res   = 1;
                    e_taken = id_rs_val[DATA_W-1];
                    pend    = 0;
                end
            end
        end
        chk("stall", stall, e_stall);
        chk("br_resolved", br_resolved, e_res);
        chk("pc_sel_br", pc_sel_br, e_taken);
        chk("flush_ifid", flush_ifid, e_taken);
`ifdef BRANCH_STATS_EN
        chk("br_taken_cnt", br_taken_cnt, m_taken);
        chk("br_total_cnt", br_total_cnt, m_total);
        chk("stall_cyc_cnt", stall_cyc_cnt, m_stall);
`else
        chk("br_taken_cnt", br_taken_cnt, 0);
        chk("br_total_cnt", br_total_cnt, 0);
        chk("stall_cyc_cnt", stall_cyc_cnt, 0);
`endif
        if (reset) begin
            n_pend = 0; n_left = 0; n_taken = 0; n_total = 0; n_stall = 0;
        end else begin
            n_pend  = pend;
            n_left  = left;
            n_taken = sat_inc(m_taken, e_taken);
            n_total = sat_inc(m_total, e_res);
            n_stall = sat_inc(m_stall, e_stall);
        end
    end

    always @(posedge clk) begin
        m_pend = n_pend; m_left = n_left;
        m_taken = n_taken; m_total = n_total; m_stall = n_stall;
    end

    // Apply one cycle of inputs shortly after the rising edge.
    task automatic drive(input bit rst, input logic [5:0] op, input int rs, input logic [31:0] val,
                         input bit exw, input bit exm, input int exrd, input bit mm, input int mrd);
        @(posedge clk); #1;
        reset = rst; id_opcode = op; id_rs = REG_W'(rs); id_rs_val = val;
        ex_regwrite = exw; ex_memread = exm; ex_rd = REG_W'(exrd);
        mem_memread = mm; mem_rd = REG_W'(mrd);
    endtask

    task automatic lit(input string name, input bit s, input bit r, input bit p, input bit f);
        @(negedge clk); #1;
        chk({name, ".stall"}, stall, s);
        chk({name, ".br_resolved"}, br_resolved, r);
        chk({name, ".pc_sel_br"}, pc_sel_br, p);
        chk({name, ".flush_ifid"}, flush_ifid, f);
    endtask

    localparam logic [5:0] BLTZ = 6'b000001;
    localparam logic [31:0] NEG = 32'hFFFF_FFF0;
    localparam logic [31:0] POS = 32'h0000_0005;

    initial begin
        reset = 1; id_opcode = 0; id_rs = 0; id_rs_val = 0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = 0; mem_memread = 0; mem_rd = 0;

        // Reset with a BLTZ already present: outputs must stay quiet.
        drive(1, BLTZ, 8, NEG, 0, 0, 0, 0, 0);      lit("reset", 0, 0, 0, 0);
        chk("reset.total_cnt", br_total_cnt, 0);

        drive(0, BLTZ, 8, NEG, 0, 0, 0, 0, 0);      lit("taken_nohaz", 0, 1, 1, 1);
        drive(0, BLTZ, 8, POS, 0, 0, 0, 0, 0);      lit("nottaken_nohaz", 0, 1, 0, 0);
        drive(0, 6'd0, 8, NEG, 0, 0, 0, 0, 0);      lit("non_bltz", 0, 0, 0, 0);

        // EX load on rs: two stalls, hazard inputs ignored while waiting, then resolve.
        drive(0, BLTZ, 9, NEG, 1, 1, 9, 0, 0);      lit("exload_c1", 1, 0, 0, 0);
        drive(0, BLTZ, 9, NEG, 0, 0, 0, 1, 9);      lit("exload_c2", 1, 0, 0, 0);
        drive(0, BLTZ, 9, NEG, 1, 1, 9, 1, 9);      lit("exload_c3", 0, 1, 1, 1);
        drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);        lit("after_exload", 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        chk("exload.stall_cyc_cnt", stall_cyc_cnt, 2);
`endif

        drive(0, BLTZ, 0, POS, 1, 0, 0, 0, 0);      lit("rs_zero", 0, 1, 0, 0);
        drive(0, BLTZ, 9, POS, 1, 0, 9, 0, 0);      lit("exalu_c1", 1, 0, 0, 0);
        drive(0, BLTZ, 9, POS, 1, 0, 9, 0, 0);      lit("exalu_c2", 0, 1, 0, 0);
        drive(0, BLTZ, 7, NEG, 0, 0, 0, 1, 7);      lit("memload_c1", 1, 0, 0, 0);
        drive(0, BLTZ, 7, NEG, 0, 0, 0, 1, 7);      lit("memload_c2", 0, 1, 1, 1);
        drive(0, BLTZ, 7, NEG, 0, 1, 6, 1, 6);      lit("other_rd", 0, 1, 1, 1);
        // Priority: EX load beats a MEM load to the same register.
        drive(0, BLTZ, 3, POS, 1, 1, 3, 1, 3);      lit("prio_c1", 1, 0, 0, 0);
        drive(0, BLTZ, 3, POS, 1, 1, 3, 1, 3);      lit("prio_c2", 1, 0, 0, 0);
        drive(0, BLTZ, 3, POS, 1, 1, 3, 1, 3);      lit("prio_c3", 0, 1, 0, 0);
        // Back-to-back: a new hazarded BLTZ right after a resolve is evaluated in IDLE.
        drive(0, BLTZ, 4, NEG, 1, 0, 4, 0, 0);      lit("b2b_c1", 1, 0, 0, 0);

        // Reset in the middle of WAIT.
        drive(0, BLTZ, 9, NEG, 0, 0, 0, 0, 0);      lit("b2b_c2", 0, 1, 1, 1);
        drive(0, BLTZ, 9, NEG, 1, 1, 9, 0, 0);      lit("wait_rst_c1", 1, 0, 0, 0);
        drive(1, BLTZ, 9, NEG, 1, 1, 9, 0, 0);      lit("wait_rst_c2", 0, 0, 0, 0);
        drive(0, 6'd0, 9, NEG, 0, 0, 0, 0, 0);      lit("post_rst", 0, 0, 0, 0);
        chk("post_rst.taken_cnt", br_taken_cnt, 0);
        chk("post_rst.total_cnt", br_total_cnt, 0);
        chk("post_rst.stall_cnt", stall_cyc_cnt, 0);

`ifdef BRANCH_STATS_EN
        // 0xFFFF+2 taken resolves must leave the taken counter pinned at all-ones.
        for (int i = 0; i < CMAX + 2; i++)
            drive(0, BLTZ, 8, NEG, 0, 0, 0, 0, 0);
        drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("sat.br_taken_cnt", br_taken_cnt, 16'hFFFF);
        chk("sat.br_total_cnt", br_total_cnt, 16'hFFFF);
`endif

        drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
